// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
//
// Run-time programmable Moore serial-pattern detector. One serial bit is taken
// per in_valid cycle. The detector tracks how many leading bits of the
// PAT_W-bit pattern are matched so far. It raises `out` while the whole pattern
// is matched and keeps a saturating count of detections. Overlap or restart
// behaviour after a full match is chosen bit by bit through `ovl`.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   load         in   1      load pat_in as the new pattern and restart detection
//   pat_in       in   PAT_W  new pattern, MSB is the first bit received
//   in_valid     in   1      qualifies `signal` for this cycle
//   signal       in   1      serial data bit
//   ovl          in   1      1 = overlapping detection, 0 = restart after a match
//   out          out  1      full-pattern match flag (registered)
//   match_count  out  CNT_W  saturating number of detections
// -----------------------------------------------------------------------------
module seq_detect_prog #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             in_valid,
  input  logic             signal,
  input  logic             ovl,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam int               S_W        = $clog2(PAT_W + 1);
  localparam logic [S_W-1:0]   FULL_C     = S_W'(PAT_W);
  localparam logic [S_W-1:0]   ZERO_S_C   = {S_W{1'b0}};
  localparam logic [PAT_W:0]   ONE_H_C    = {{PAT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};

  // KMP-style failure transition built only from the pattern. The history
  // string h is the matched prefix (or nothing after a non-overlapping match)
  // with the new bit appended. The result is the longest pattern prefix that
  // is also a suffix of h. h is held right-aligned in a PAT_W+1 bit vector,
  // and only its low len_v bits are meaningful.
  function automatic logic [S_W-1:0] next_state_f(
    input logic [PAT_W-1:0] pat_v,
    input logic [S_W-1:0]   s_v,
    input logic             ovl_v,
    input logic             bit_v
  );
    logic [PAT_W:0] h_v;
    logic [PAT_W:0] mask_v;
    logic [PAT_W:0] pre_v;
    logic [S_W-1:0] best_v;
    int             base_v;
    int             len_v;
    if ((s_v == FULL_C) && !ovl_v) begin
      base_v = 0;
    end else begin
      base_v = int'(s_v);
    end
    h_v    = {1'b0, pat_v} >> (PAT_W - base_v);
    h_v    = {h_v[PAT_W-1:0], bit_v};
    len_v  = base_v + 1;
    best_v = ZERO_S_C;
    // Ascending scan, so the longest matching prefix is the one kept.
    for (int k = 1; k <= PAT_W; k++) begin
      mask_v = (ONE_H_C << k) - ONE_H_C;
      pre_v  = {1'b0, pat_v} >> (PAT_W - k);
      if ((k <= len_v) && ((h_v & mask_v) == pre_v)) begin
        best_v = S_W'(k);
      end else begin
        best_v = best_v;
      end
    end
    return best_v;
  endfunction

  logic [S_W-1:0]   s_r;
  logic [PAT_W-1:0] pat_r;
  logic             out_r;
  logic [CNT_W-1:0] cnt_r;
  logic [S_W-1:0]   ns_s;
  logic             hit_s;

  // Next-state and full-match decode for the current serial bit.
  always_comb begin
    ns_s  = next_state_f(pat_r, s_r, ovl, signal);
    hit_s = 1'b0;
    if (ns_s == FULL_C) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // State, pattern, match flag and counter registers. Priority is reset,
  // then load, then a valid bit. The match flag is registered together with
  // the state, so it always equals (s_r == PAT_W) and never depends
  // combinationally on `signal`.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r   <= ZERO_S_C;
      pat_r <= PATTERN;
      out_r <= 1'b0;
      cnt_r <= CNT_ZERO_C;
    end else if (load) begin
      pat_r <= pat_in;
      s_r   <= ZERO_S_C;
      out_r <= 1'b0;
    end else if (in_valid) begin
      s_r   <= ns_s;
      out_r <= hit_s;
      if (hit_s && (cnt_r != CNT_MAX_C)) begin
        cnt_r <= cnt_r + CNT_ONE_C;
      end
    end
  end

  assign out         = out_r;
  assign match_count = cnt_r;

endmodule

// File: tb/tb_seq_detect_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_prog
//
// Self-checking bench for seq_detect_prog. It uses two instances:
//   dut_a : defaults (PAT_W=4, PATTERN=1011, CNT_W=8), driven from a table
//   dut_b : PAT_W=3, PATTERN=101, CNT_W=2, driven by hand-written sequences
// Inputs change on the falling edge. Outputs are checked 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a stimulus and outputs
  logic       a_rst, a_load, a_valid, a_sig, a_ovl;
  logic [3:0] a_pat;
  logic       a_out;
  logic [7:0] a_cnt;

  // dut_b stimulus and outputs
  logic       b_rst, b_load, b_valid, b_sig, b_ovl;
  logic [2:0] b_pat;
  logic       b_out;
  logic [1:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  seq_detect_prog dut_a (
    .clk(clk), .rst(a_rst), .load(a_load), .pat_in(a_pat),
    .in_valid(a_valid), .signal(a_sig), .ovl(a_ovl),
    .out(a_out), .match_count(a_cnt)
  );

  seq_detect_prog #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .load(b_load), .pat_in(b_pat),
    .in_valid(b_valid), .signal(b_sig), .ovl(b_ovl),
    .out(b_out), .match_count(b_cnt)
  );

  typedef struct {
    logic       rst;
    logic       load;
    logic       valid;
    logic       sig;
    logic       ovl;
    logic [3:0] pat;
    logic       eo;
    logic [7:0] ec;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic ld, input logic v,
                              input logic sg, input logic o, input logic [3:0] p,
                              input logic eo, input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.load = ld; t.valid = v; t.sig = sg; t.ovl = o;
    t.pat = p; t.eo = eo; t.ec = ec;
    vq.push_back(t);
  endfunction

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // One cycle on dut_b followed by a check of out and match_count.
  task automatic b_step(input string nm, input logic r, input logic v,
                        input logic sg, input logic o,
                        input logic eo, input logic [1:0] ec);
    @(negedge clk);
    b_rst = r; b_valid = v; b_sig = sg; b_ovl = o;
    @(posedge clk);
    #1;
    check({nm, "_out"}, {31'd0, b_out}, {31'd0, eo});
    check({nm, "_cnt"}, {30'd0, b_cnt}, {30'd0, ec});
  endtask

  initial begin
    a_rst = 1'b1; a_load = 1'b0; a_valid = 1'b0; a_sig = 1'b0; a_ovl = 1'b0; a_pat = 4'd0;
    b_rst = 1'b1; b_load = 1'b0; b_valid = 1'b0; b_sig = 1'b0; b_ovl = 1'b0; b_pat = 3'd0;

    // ---------------- dut_a table: rst, load, valid, sig, ovl, pat, out, cnt
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0);   // reset state
    // 1011, overlap: 1,0,1,0,1,1,0,1,1 -> hits after bits 6 and 9
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'd0);   // 101+0 -> s=2
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 8'd1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'd1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 8'd2);
    // gaps after a match: out holds
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 8'd2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 8'd2);
    // non-overlap restart, then 1011 with gaps mid-pattern
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd2);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 8'd3);
    // ovl=0 restart: 1,0 -> s=2, then load with valid=1 (bit dropped)
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd3);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 8'd3);
    // 1111 overlap: six 1s -> hits after 4, 5, 6
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd3);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 8'd4);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 8'd5);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 8'd6);
    // 1111 non-overlap: six 1s -> one hit after bit 4, ends at s=2
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd6);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd6);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd6);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 8'd7);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd7);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd7);
    // load 0110, match it, then load while out=1 drops out
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 8'd7);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'd7);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd7);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd7);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 8'd8);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 8'd8);
    // 0,1,1 -> s=3, then rst beats load/valid; pattern back to 1011
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'd8);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd8);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd8);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 8'd0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 8'd1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      a_rst = vq[i].rst; a_load = vq[i].load; a_valid = vq[i].valid;
      a_sig = vq[i].sig; a_ovl = vq[i].ovl;   a_pat = vq[i].pat;
      @(posedge clk);
      #1;
      check($sformatf("a_row%0d_out", i), {31'd0, a_out}, {31'd0, vq[i].eo});
      check($sformatf("a_row%0d_cnt", i), {24'd0, a_cnt}, {24'd0, vq[i].ec});
    end

    // ---------------- dut_b: PAT_W=3, pattern 101, CNT_W=2
    b_step("b_rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    // non-overlap 1,0,1,0,1 -> only after bit 3
    b_step("b_no1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    b_step("b_no2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    b_step("b_no3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
    b_step("b_no4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    b_step("b_no5", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    b_step("b_rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    // overlap 1,0,1,0,1 -> after bits 3 and 5
    b_step("b_ov1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    b_step("b_ov2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    b_step("b_ov3", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
    b_step("b_ov4", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
    b_step("b_ov5", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
    // three more hits: count saturates at 3, out still pulses
    b_step("b_sat1a", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
    b_step("b_sat1b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
    b_step("b_sat2a", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    b_step("b_sat2b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
    b_step("b_sat3a", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    b_step("b_sat3b", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
    // 1,0 -> s=2 mid-pattern, then reset
    b_step("b_mid1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3);
    b_step("b_mid2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3);
    b_step("b_rst2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    // after reset the prefix is gone: a lone 1 does not complete a match
    b_step("b_post", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
